data_mem_lat: RTL and testbench

Parametrised successor to the single-cycle data memory path. It provides a word-organised data memory with configurable depth and configurable read/write latency, fronted by a valid/ready request and single-cycle response handshake, so the core can stall on memory. It performs RV32I byte/half/word lane steering, load sign/zero extension, and misalignment and range fault detection internally. It sits between the datapath load/store unit and the core top, replacing the combinational-read data memory.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_lane_fmt.sv | 70 +++++++
 rtl/data_mem_lat.sv | 100 ++++++++++
 tb/tb_data_mem_lat.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the latency-configurable data memory and its lane formatter.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Width of a word index into an array of depth_words entries.
  function automatic int word_addr_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational RV32I lane steering: store byte enables, load extract/extend and fault decode.
module mem_lane_fmt
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [1:0]  off;
  logic [31:0] shifted;

  assign off     = addr[1:0];
  assign shifted = rword >> {off, 3'b000};

  always_comb begin
    fault = 1'b0;
    case (funct3)
      F3_B, F3_BU: fault = 1'b0;
      F3_H, F3_HU: fault = addr[0];
      F3_W:        fault = (off != 2'b00);
      default:     fault = 1'b1;
    endcase
    if (we && (funct3 == F3_BU || funct3 == F3_HU)) fault = 1'b1;
    // Out-of-range addresses fault rather than wrapping onto a low word.
    if (addr[31:2] >= 30'(DEPTH_WORDS)) fault = 1'b1;
  end

  // Replicating the store data lets the byte enables alone pick the lanes.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = wdata;
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
      end
      F3_H: begin
        byte_en    = 4'b0011 << {off[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
      end
      F3_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    if (!we || fault) byte_en = 4'b0000;
  end

  always_comb begin
    load_data = 32'h0;
    if (!we && !fault) begin
      case (funct3)
        F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
        F3_BU:   load_data = {24'h0, shifted[7:0]};
        F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
        F3_HU:   load_data = {16'h0, shifted[15:0]};
        F3_W:    load_data = shifted;
        default: load_data = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_lat.sv
// Word-organised data memory with a valid/ready request, configurable response latency
// and a single-cycle response pulse.
module data_mem_lat
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int AW = word_addr_w(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic          accept;
  logic [AW-1:0] word_idx;
  logic [31:0]   rword;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lane;
  logic [31:0]   load_data;
  logic          fault;

  assign req_ready = (state != WAIT);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[AW+1:2];
  assign rword     = mem[word_idx];

  mem_lane_fmt #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_fmt (
    .we         (req_we),
    .funct3     (req_funct3),
    .addr       (req_addr),
    .wdata      (req_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .load_data  (load_data),
    .fault      (fault)
  );

  // Stores commit at the accept edge so a back-to-back load sees them.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          cnt_nxt   = 3'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rsp_rdata <= load_data;
        rsp_fault <= fault;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lat.sv
// Randomised bench for data_mem_lat: three instances (LATENCY 3, 1, 4) checked against a
// byte-level memory model and a per-instance scoreboard of expected responses.
module tb_data_mem_lat;

  localparam int N_DUT = 3;
  localparam int DEPTH = 128;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 3;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst        [N_DUT];
  logic        req_valid  [N_DUT];
  logic        req_ready  [N_DUT];
  logic        req_we     [N_DUT];
  logic [31:0] req_addr   [N_DUT];
  logic [2:0]  req_funct3 [N_DUT];
  logic [31:0] req_wdata  [N_DUT];
  logic        rsp_valid  [N_DUT];
  logic [31:0] rsp_rdata  [N_DUT];
  logic        rsp_fault  [N_DUT];

  exp_t        sb [N_DUT][$];
  logic [7:0]  model_mem [N_DUT][512];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    data_mem_lat #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (lat_of(g))
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_funct3 (req_funct3[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_fault  (rsp_fault[g])
    );

    always @(negedge clk) begin
      if (rsp_valid[g] === 1'b1) begin
        if (sb[g].size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb[g].pop_front();
          checkOutput("rsp_cycle", 32'(cyc), 32'(e.due));
          checkOutput("rsp_rdata", rsp_rdata[g], e.rdata);
          checkOutput("rsp_fault", 32'(rsp_fault[g]), 32'(e.fault));
        end
      end
    end
  end

  // Reference: decode the access by size/alignment/range, then act on individual bytes.
  task automatic ref_access(input int d, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic flt);
    int size;
    int a;
    flt = 1'b0;
    rd  = 32'h0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default: begin size = 1; flt = 1'b1; end
    endcase
    if (we && (f3 == 3'd4 || f3 == 3'd5)) flt = 1'b1;
    if ((int'(addr[1:0]) % size) != 0) flt = 1'b1;
    if ((addr >> 2) >= 32'(DEPTH)) flt = 1'b1;
    if (!flt) begin
      a = int'(addr[8:0]);
      if (we) begin
        for (int i = 0; i < size; i++) model_mem[d][a + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd = rd | (32'(model_mem[d][a + i]) << (8*i));
        if ((f3 == 3'd0 || f3 == 3'd1) && rd[8*size - 1]) rd = rd | (32'hFFFF_FFFF << (8*size));
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept with req_valid still high.
  task automatic applyStimulus(input int d, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int   n;
    exp_t e;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_valid[d]  = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    ref_access(d, we, f3, addr, wdata, e.rdata, e.fault);
    e.due = cyc + lat_of(d);
    sb[d].push_back(e);
    @(negedge clk);
  endtask

  task automatic release_req(input int d, input int gap);
    req_valid[d] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (sb[d].size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(sb[d].size()), 32'd0);
  endtask

  logic [2:0] f3_ok [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] f3_bad [3] = '{3'd3, 3'd6, 3'd7};

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int d = 0; d < N_DUT; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_addr[d] = 32'h0; req_funct3[d] = 3'd2; req_wdata[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      checkOutput("rst_ready", 32'(req_ready[d]), 32'd1);
      checkOutput("rst_valid", 32'(rsp_valid[d]), 32'd0);
      checkOutput("rst_rdata", rsp_rdata[d], 32'd0);
      checkOutput("rst_fault", 32'(rsp_fault[d]), 32'd0);
      rst[d] = 1'b0;
    end
    @(negedge clk);

    $display("[TB] filling words 0..15 of each instance");
    for (int d = 0; d < N_DUT; d++) begin
      for (int w = 0; w < 16; w++) applyStimulus(d, 1'b1, 3'd2, 32'(w * 4), $urandom);
      release_req(d, 1);
      drain(d);
    end

    $display("[TB] directed lane and fault sequence (LATENCY 3)");
    applyStimulus(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF); release_req(0, 0);
    applyStimulus(0, 1'b0, 3'd2, 32'h10, 32'h0);         release_req(0, 3);
    applyStimulus(0, 1'b1, 3'd0, 32'h11, 32'h0000_0080);
    applyStimulus(0, 1'b0, 3'd0, 32'h11, 32'h0);
    applyStimulus(0, 1'b0, 3'd4, 32'h11, 32'h0);
    applyStimulus(0, 1'b0, 3'd2, 32'h10, 32'h0);
    applyStimulus(0, 1'b0, 3'd1, 32'h13, 32'h0);
    applyStimulus(0, 1'b1, 3'd2, 32'h202, 32'hCAFE_F00D);
    applyStimulus(0, 1'b0, 3'd2, 32'h200, 32'h0);
    applyStimulus(0, 1'b0, 3'd2, 32'h0, 32'h0);
    release_req(0, 0);
    drain(0);

    $display("[TB] reset while a store is in flight");
    applyStimulus(0, 1'b1, 3'd2, 32'h20, 32'h1234_5678);
    release_req(0, 0);
    rst[0] = 1'b1;
    sb[0].delete();
    @(negedge clk);
    rst[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("no_rsp_after_rst", 32'(rsp_valid[0]), 32'd0);
      @(negedge clk);
    end
    applyStimulus(0, 1'b0, 3'd2, 32'h20, 32'h0);
    release_req(0, 0);
    drain(0);

    $display("[TB] back-to-back requests (LATENCY 1)");
    applyStimulus(1, 1'b1, 3'd2, 32'h08, 32'hA5A5_0001);
    applyStimulus(1, 1'b0, 3'd2, 32'h08, 32'h0);
    applyStimulus(1, 1'b1, 3'd1, 32'h0A, 32'h0000_8001);
    applyStimulus(1, 1'b0, 3'd5, 32'h0A, 32'h0);
    release_req(1, 0);
    drain(1);

    $display("[TB] request offered during WAIT is ignored (LATENCY 4)");
    applyStimulus(2, 1'b0, 3'd2, 32'h10, 32'h0);
    release_req(2, 0);
    checkOutput("ready_in_wait", 32'(req_ready[2]), 32'd0);
    req_we[2] = 1'b1; req_funct3[2] = 3'd2; req_addr[2] = 32'h14; req_wdata[2] = 32'h0BAD_0BAD;
    req_valid[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (6) @(negedge clk);
    drain(2);
    applyStimulus(2, 1'b0, 3'd2, 32'h14, 32'h0);
    release_req(2, 0);
    drain(2);

    $display("[TB] randomised traffic");
    for (int d = 0; d < N_DUT; d++) begin
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 9) < 8) f3 = f3_ok[$urandom_range(0, 4)];
        else                          f3 = f3_bad[$urandom_range(0, 2)];
        if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h0000_0200;
        else                           addr = 32'($urandom_range(0, 63));
        applyStimulus(d, 1'($urandom_range(0, 1)), f3, addr, $urandom);
        if ($urandom_range(0, 1) == 1) release_req(d, $urandom_range(0, 3));
      end
      release_req(d, 0);
      drain(d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
